matmul_sequencer: RTL and testbench

Control FSM that sequences one C = A x B matrix multiply over a shared single-port data memory and one MAC datapath.
Walks the i/j/k loop nest and generates A, B and C addresses from running address registers (increment/reload only, no multiplier).
Drives the MAC accumulator clear and enable, and issues read and write requests with a req/ack handshake.
Sits between the processor's control unit (start/done) and the memory and MAC datapath.

---
 rtl/matmul_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: control FSM that sequences one C = A x B matrix multiply.
// It walks the i/j/k loop nest over row-major matrices in a shared single-port
// memory and drives one MAC datapath. Operand and result addresses come from
// running address registers that only increment or reload, so no multiplier
// is needed. Memory reads and writes use a req/ack handshake.
module matmul_sequencer #(
    parameter int word_size = 16,
    parameter int dim_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [dim_width-1:0] dim_m,
    input  logic [dim_width-1:0] dim_n,
    input  logic [dim_width-1:0] dim_p,
    input  logic [word_size-1:0] base_a,
    input  logic [word_size-1:0] base_b,
    input  logic [word_size-1:0] base_c,
    output logic                 rd_req,
    input  logic                 rd_ack,
    output logic                 wr_req,
    input  logic                 wr_ack,
    output logic [word_size-1:0] addr_a,
    output logic [word_size-1:0] addr_b,
    output logic [word_size-1:0] addr_c,
    output logic                 mac_en,
    output logic                 mac_clr,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MAC   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Loop counters and the dimensions latched when the operation starts.
    logic [dim_width-1:0] i_cnt;
    logic [dim_width-1:0] j_cnt;
    logic [dim_width-1:0] k_cnt;
    logic [dim_width-1:0] m_lat;
    logic [dim_width-1:0] n_lat;
    logic [dim_width-1:0] p_lat;

    // base_b is needed again at every column and row change; A and C only
    // ever step forward or rewind relative to their own running register.
    logic [word_size-1:0] base_b_lat;

    logic zero_dim;
    logic k_last;
    logic j_last;
    logic i_last;

    // Loop-end decodes. The latched dimensions are never 0 while the loop
    // states are active, so the minus-one terms cannot underflow there.
    always_comb begin
        zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);
        k_last   = (k_cnt == n_lat - dim_width'(1));
        j_last   = (j_cnt == p_lat - dim_width'(1));
        i_last   = (i_cnt == m_lat - dim_width'(1));
    end

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the Moore-style control outputs.
    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_dim ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_req = 1'b1;
                busy   = 1'b1;
                if (rd_ack) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en     = 1'b1;
                mac_clr    = (k_cnt == '0);
                busy       = 1'b1;
                state_next = k_last ? STORE : FETCH;
            end
            STORE: begin
                wr_req = 1'b1;
                busy   = 1'b1;
                if (wr_ack) begin
                    state_next = (j_last && i_last) ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Loop counters, latched operands and the running address registers.
    // A steps by 1 along a row and rewinds by N-1 to restart the row; B steps
    // by P down a column and reloads from base_b plus the column index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt      <= '0;
            j_cnt      <= '0;
            k_cnt      <= '0;
            m_lat      <= '0;
            n_lat      <= '0;
            p_lat      <= '0;
            base_b_lat <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_lat      <= dim_m;
                        n_lat      <= dim_n;
                        p_lat      <= dim_p;
                        base_b_lat <= base_b;
                        i_cnt      <= '0;
                        j_cnt      <= '0;
                        k_cnt      <= '0;
                        addr_a     <= base_a;
                        addr_b     <= base_b;
                        addr_c     <= base_c;
                    end
                end
                MAC: begin
                    if (!k_last) begin
                        k_cnt  <= k_cnt + dim_width'(1);
                        addr_a <= addr_a + word_size'(1);
                        addr_b <= addr_b + word_size'(p_lat);
                    end
                end
                STORE: begin
                    if (wr_ack) begin
                        addr_c <= addr_c + word_size'(1);
                        k_cnt  <= '0;
                        if (!j_last) begin
                            j_cnt  <= j_cnt + dim_width'(1);
                            addr_a <= addr_a - (word_size'(n_lat) - word_size'(1));
                            addr_b <= base_b_lat + word_size'(j_cnt) + word_size'(1);
                        end else if (!i_last) begin
                            i_cnt  <= i_cnt + dim_width'(1);
                            j_cnt  <= '0;
                            addr_a <= addr_a + word_size'(1);
                            addr_b <= base_b_lat;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed self-checking bench for matmul_sequencer.
// Each run logs completed read/write handshakes and control activity, then
// compares them against hand-computed address tables and cycle counts.
module tb_matmul_sequencer;

    localparam int WS = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dim_m = '0;
    logic [DW-1:0] dim_n = '0;
    logic [DW-1:0] dim_p = '0;
    logic [WS-1:0] base_a = '0;
    logic [WS-1:0] base_b = '0;
    logic [WS-1:0] base_c = '0;
    logic          rd_req;
    logic          rd_ack = 1'b0;
    logic          wr_req;
    logic          wr_ack = 1'b0;
    logic [WS-1:0] addr_a;
    logic [WS-1:0] addr_b;
    logic [WS-1:0] addr_c;
    logic          mac_en;
    logic          mac_clr;
    logic          busy;
    logic          done;

    matmul_sequencer #(.word_size(WS), .dim_width(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dim_m   (dim_m),
        .dim_n   (dim_n),
        .dim_p   (dim_p),
        .base_a  (base_a),
        .base_b  (base_b),
        .base_c  (base_c),
        .rd_req  (rd_req),
        .rd_ack  (rd_ack),
        .wr_req  (wr_req),
        .wr_ack  (wr_ack),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .addr_c  (addr_c),
        .mac_en  (mac_en),
        .mac_clr (mac_clr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    // Memory-side responder configuration.
    bit ack_tied = 1'b1;
    int rd_delay = 0;
    int wr_delay = 0;
    int rd_wait  = 0;
    int wr_wait  = 0;

    // Run logs.
    logic [WS-1:0] rd_a_q[$];
    logic [WS-1:0] rd_b_q[$];
    logic [WS-1:0] wr_c_q[$];
    int            busy_cycles;
    int            done_pulses;
    int            rd_req_cycles;
    int            wr_req_cycles;
    int            overlap_errs;
    int            stab_errs;
    int            mac_count;
    logic [31:0]   clr_pattern;
    logic          prev_rd_wait;
    logic          prev_wr_wait;
    logic [WS-1:0] prev_a;
    logic [WS-1:0] prev_b;
    logic [WS-1:0] prev_c;

    // Expected tables.
    int exp_a[$];
    int exp_b[$];
    int exp_c[$];

    // Memory responder: either acks tied high, or ack after a fixed wait.
    always @(posedge clk) begin
        #2;
        if (ack_tied) begin
            rd_ack = 1'b1;
            wr_ack = 1'b1;
        end else begin
            if (rd_req) begin
                rd_ack = (rd_wait >= rd_delay);
                rd_wait++;
            end else begin
                rd_ack  = 1'b0;
                rd_wait = 0;
            end
            if (wr_req) begin
                wr_ack = (wr_wait >= wr_delay);
                wr_wait++;
            end else begin
                wr_ack  = 1'b0;
                wr_wait = 0;
            end
        end
    end

    // Monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (done) done_pulses++;
        if (rd_req) rd_req_cycles++;
        if (wr_req) wr_req_cycles++;
        if (rd_req && wr_req) overlap_errs++;
        if (prev_rd_wait && rd_req && (addr_a != prev_a || addr_b != prev_b)) stab_errs++;
        if (prev_wr_wait && wr_req && (addr_c != prev_c)) stab_errs++;
        if (rd_req && rd_ack) begin
            rd_a_q.push_back(addr_a);
            rd_b_q.push_back(addr_b);
        end
        if (wr_req && wr_ack) wr_c_q.push_back(addr_c);
        if (mac_en) begin
            mac_count++;
            clr_pattern = {clr_pattern[30:0], mac_clr};
        end
        prev_rd_wait = rd_req && !rd_ack;
        prev_wr_wait = wr_req && !wr_ack;
        prev_a = addr_a;
        prev_b = addr_b;
        prev_c = addr_c;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        rd_a_q.delete();
        rd_b_q.delete();
        wr_c_q.delete();
        busy_cycles   = 0;
        done_pulses   = 0;
        rd_req_cycles = 0;
        wr_req_cycles = 0;
        overlap_errs  = 0;
        stab_errs     = 0;
        mac_count     = 0;
        clr_pattern   = '0;
        prev_rd_wait  = 1'b0;
        prev_wr_wait  = 1'b0;
    endtask

    // Launch one operation and wait (bounded) for done. poke_cycle > 0 pulses
    // start again with different operands while the operation is running.
    task automatic applyStimulus(input int m, input int n, input int p,
                                 input int ba, input int bb, input int bc,
                                 input bit tied, input int rdd, input int wrd,
                                 input int poke_cycle, output int latency);
        bit got_done;
        @(posedge clk);
        #1;
        clearLog();
        ack_tied = tied;
        rd_delay = rdd;
        wr_delay = wrd;
        @(negedge clk);
        dim_m  = DW'(m);
        dim_n  = DW'(n);
        dim_p  = DW'(p);
        base_a = WS'(ba);
        base_b = WS'(bb);
        base_c = WS'(bc);
        start  = 1'b1;
        latency  = 0;
        got_done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = 1'b0;
            latency++;
            if (latency == poke_cycle) begin
                start  = 1'b1;
                dim_m  = 8'd1;
                dim_n  = 8'd1;
                dim_p  = 8'd1;
                base_a = 16'h0040;
                base_b = 16'h0050;
                base_c = 16'h0060;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) begin
            checkOutput("done timeout", 32'd0, 32'd1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkSequence(input string tag);
        checkOutput({tag, " read count"}, 32'(rd_a_q.size()), 32'(exp_a.size()));
        checkOutput({tag, " write count"}, 32'(wr_c_q.size()), 32'(exp_c.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            checkOutput($sformatf("%s rd_a[%0d]", tag, i),
                        (i < rd_a_q.size()) ? 32'(rd_a_q[i]) : 32'hDEAD_BEEF, 32'(exp_a[i]));
            checkOutput($sformatf("%s rd_b[%0d]", tag, i),
                        (i < rd_b_q.size()) ? 32'(rd_b_q[i]) : 32'hDEAD_BEEF, 32'(exp_b[i]));
        end
        for (int i = 0; i < exp_c.size(); i++) begin
            checkOutput($sformatf("%s wr_c[%0d]", tag, i),
                        (i < wr_c_q.size()) ? 32'(wr_c_q[i]) : 32'hDEAD_BEEF, 32'(exp_c[i]));
        end
        checkOutput({tag, " mac count"}, 32'(mac_count), 32'(exp_a.size()));
        checkOutput({tag, " done pulses"}, 32'(done_pulses), 32'd1);
        checkOutput({tag, " rd/wr overlap"}, 32'(overlap_errs), 32'd0);
    endtask

    task automatic load2x2x2();
        exp_a = '{0, 1, 0, 1, 2, 3, 2, 3};
        exp_b = '{16, 18, 17, 19, 16, 18, 17, 19};
        exp_c = '{32, 33, 34, 35};
    endtask

    initial begin
        int lat;

        // Reset state.
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset ctrl", {26'd0, rd_req, wr_req, mac_en, mac_clr, busy, done}, 32'd0);
        checkOutput("reset addr_a", 32'(addr_a), 32'd0);
        checkOutput("reset addr_b", 32'(addr_b), 32'd0);
        checkOutput("reset addr_c", 32'(addr_c), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1x1x1, acks tied high.
        applyStimulus(1, 1, 1, 0, 16, 32, 1'b1, 0, 0, 0, lat);
        exp_a = '{0};
        exp_b = '{16};
        exp_c = '{32};
        checkSequence("1x1x1");
        checkOutput("1x1x1 latency", 32'(lat), 32'd4);
        checkOutput("1x1x1 busy", 32'(busy_cycles), 32'd3);
        checkOutput("1x1x1 clr", clr_pattern, 32'h1);

        // 2x2x2, acks tied high.
        applyStimulus(2, 2, 2, 0, 16, 32, 1'b1, 0, 0, 0, lat);
        load2x2x2();
        checkSequence("2x2x2");
        checkOutput("2x2x2 latency", 32'(lat), 32'd21);
        checkOutput("2x2x2 busy", 32'(busy_cycles), 32'd20);
        checkOutput("2x2x2 clr", clr_pattern, 32'hAA);

        // 2x2x2 with delayed acks.
        applyStimulus(2, 2, 2, 0, 16, 32, 1'b0, 3, 2, 0, lat);
        load2x2x2();
        checkSequence("slow");
        checkOutput("slow latency", 32'(lat), 32'd53);
        checkOutput("slow busy", 32'(busy_cycles), 32'd52);
        checkOutput("slow stability", 32'(stab_errs), 32'd0);
        checkOutput("slow rd_req cycles", 32'(rd_req_cycles), 32'd32);
        checkOutput("slow wr_req cycles", 32'(wr_req_cycles), 32'd12);
        checkOutput("slow clr", clr_pattern, 32'hAA);

        // Zero dimension: no traffic, done right away.
        applyStimulus(2, 0, 2, 0, 16, 32, 1'b1, 0, 0, 0, lat);
        checkOutput("zero latency", 32'(lat), 32'd1);
        checkOutput("zero rd_req", 32'(rd_req_cycles), 32'd0);
        checkOutput("zero wr_req", 32'(wr_req_cycles), 32'd0);
        checkOutput("zero busy", 32'(busy_cycles), 32'd0);
        checkOutput("zero mac", 32'(mac_count), 32'd0);
        checkOutput("zero done", 32'(done_pulses), 32'd1);

        // Reset during the second FETCH of a 2x2x2 run.
        @(posedge clk);
        #1;
        clearLog();
        ack_tied = 1'b1;
        @(negedge clk);
        dim_m  = 8'd2;
        dim_n  = 8'd2;
        dim_p  = 8'd2;
        base_a = 16'd0;
        base_b = 16'd16;
        base_c = 16'd32;
        start  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("abort in fetch", 32'(rd_req), 32'd1);
        checkOutput("abort addr_a", 32'(addr_a), 32'd1);
        checkOutput("abort addr_b", 32'(addr_b), 32'd18);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort ctrl", {26'd0, rd_req, wr_req, mac_en, mac_clr, busy, done}, 32'd0);
        checkOutput("abort addrs", {addr_a, addr_b | addr_c}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort no done", 32'(done_pulses), 32'd0);

        // Fresh run after the abort.
        applyStimulus(2, 2, 2, 0, 16, 32, 1'b1, 0, 0, 0, lat);
        load2x2x2();
        checkSequence("rerun");
        checkOutput("rerun latency", 32'(lat), 32'd21);

        // start pulsed mid-run with different operands is ignored.
        applyStimulus(2, 2, 2, 0, 16, 32, 1'b1, 0, 0, 5, lat);
        load2x2x2();
        checkSequence("poke");
        checkOutput("poke latency", 32'(lat), 32'd21);
        checkOutput("poke busy", 32'(busy_cycles), 32'd20);

        // C address wraps from FFFF to 0000.
        applyStimulus(1, 1, 2, 16'h0100, 16'h0200, 16'hFFFF, 1'b1, 0, 0, 0, lat);
        exp_a = '{16'h0100, 16'h0100};
        exp_b = '{16'h0200, 16'h0201};
        exp_c = '{16'hFFFF, 16'h0000};
        checkSequence("wrap");
        checkOutput("wrap latency", 32'(lat), 32'd7);
        checkOutput("wrap clr", clr_pattern, 32'h3);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
